// File: rtl/spi_stream_engine.sv
// =============================================================================
// Module   : spi_stream_engine
// Purpose  : Bus-master sequencer in front of the epRISC SPI peripheral. The
//            CPU queues bytes into a TX FIFO. For each byte the engine loads
//            the SPI data register, starts the transfer, polls busy, reads the
//            received byte back and queues it into an RX FIFO.
// Revision : 1.0 - initial release
// -----------------------------------------------------------------------------
// Ports
//   iClk, iRst        clock, synchronous active-high reset
//   iAddr/iData/oData CPU register port (0 CTRL/STAT, 1 FIFO data,
//   iWrite/iEnable    2 TX count, 3 RX count / SPI control template)
//   oInt              level interrupt (drain or error, gated by IRQEN)
//   oSpi*/iSpiData    registered master strobes toward the SPI peripheral
// =============================================================================
`default_nettype none

module spi_stream_engine #(
  parameter int DEPTH      = 16,
  parameter int POLL_LIMIT = 4096
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [1:0]  iAddr,
  input  logic [15:0] iData,
  output logic [15:0] oData,
  input  logic        iWrite,
  input  logic        iEnable,
  output logic        oInt,
  output logic [1:0]  oSpiAddr,
  output logic [15:0] oSpiData,
  input  logic [15:0] iSpiData,
  output logic        oSpiWrite,
  output logic        oSpiEnable
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(POLL_LIMIT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GO, S_POLL, S_READ} state_t;

  state_t state, state_nxt;

  logic          run, irqen, discard, ovf, tmo;
  logic [15:0]   tpl;
  logic [PW-1:0] poll_cnt;

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0] tx_cnt, rx_cnt;

  logic cpu_wr, cpu_rd;
  logic tx_push_req, tx_push, tx_pop, rx_push, rx_pop;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic poll_busy, poll_last, timeout;
  logic [15:0] rd_data;

  logic        spi_en_nxt, spi_wr_nxt;
  logic [1:0]  spi_addr_nxt;
  logic [15:0] spi_data_nxt;

  // Only the low byte of a received word is payload; bit 7 of the control
  // word is the busy flag. The high byte has no meaning here.
  logic unused_spi_hi;
  assign unused_spi_hi = ^iSpiData[15:8];

  assign cpu_wr = iEnable & iWrite;
  assign cpu_rd = iEnable & ~iWrite;

  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == CW'(DEPTH));
  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == CW'(DEPTH));

  assign tx_push_req = cpu_wr && (iAddr == 2'd1);
  assign tx_push     = tx_push_req && !tx_full;
  assign tx_pop      = (state == S_LOAD);
  // Guarded against full in case DISCARD is cleared while a byte is in flight.
  assign rx_push     = (state == S_READ) && !discard && !rx_full;
  assign rx_pop      = cpu_rd && (iAddr == 2'd1) && !rx_empty;

  assign poll_busy = iSpiData[7];
  assign poll_last = (poll_cnt == PW'(POLL_LIMIT - 1));
  assign timeout   = (state == S_POLL) && poll_busy && poll_last;

  // ---------------------------------------------------------------- FIFOs
  always_ff @(posedge iClk) begin
    if (tx_push) tx_mem[tx_wp] <= iData[7:0];
    if (rx_push) rx_mem[rx_wp] <= iSpiData[7:0];
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 1'b1;

      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
      else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 1'b1;
    end
  end

  // ------------------------------------------------------ control register
  always_ff @(posedge iClk) begin
    if (iRst) begin
      run     <= 1'b0;
      irqen   <= 1'b0;
      discard <= 1'b0;
      ovf     <= 1'b0;
      tmo     <= 1'b0;
      tpl     <= 16'h0000;
    end else begin
      if (cpu_wr && (iAddr == 2'd0)) begin
        run     <= iData[0];
        irqen   <= iData[1];
        discard <= iData[2];
      end
      if (cpu_wr && (iAddr == 2'd3)) tpl <= iData;

      // Setting events win over a simultaneous write-1-to-clear.
      if (tx_push_req && tx_full)                      ovf <= 1'b1;
      else if (cpu_wr && (iAddr == 2'd0) && iData[13]) ovf <= 1'b0;

      if (timeout) begin
        tmo <= 1'b1;
        run <= 1'b0;
      end else if (cpu_wr && (iAddr == 2'd0) && iData[14]) begin
        tmo <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------- poll count
  always_ff @(posedge iClk) begin
    if (iRst || (state == S_GO))                      poll_cnt <= '0;
    else if ((state == S_POLL) && poll_busy && !poll_last) poll_cnt <= poll_cnt + 1'b1;
  end

  // --------------------------------------------------------------------- FSM
  always_ff @(posedge iClk) begin
    if (iRst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // SPI strobes are decoded from the next state and registered, so each one
  // is high exactly during the cycle spent in the matching state.
  always_comb begin
    state_nxt    = state;
    spi_en_nxt   = 1'b0;
    spi_wr_nxt   = 1'b0;
    spi_addr_nxt = 2'd0;
    spi_data_nxt = 16'h0000;
    case (state)
      S_IDLE: if (run && !tx_empty && (discard || !rx_full)) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_GO;
      S_GO:   state_nxt = S_POLL;
      S_POLL: begin
        if (!poll_busy)     state_nxt = S_READ;
        else if (poll_last) state_nxt = S_IDLE;
      end
      S_READ: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    case (state_nxt)
      S_LOAD: begin
        spi_en_nxt   = 1'b1;
        spi_wr_nxt   = 1'b1;
        spi_addr_nxt = 2'd1;
        spi_data_nxt = {8'h00, tx_mem[tx_rp]};
      end
      S_GO: begin
        spi_en_nxt   = 1'b1;
        spi_wr_nxt   = 1'b1;
        spi_data_nxt = tpl | 16'h0080;
      end
      S_POLL: spi_en_nxt = 1'b1;
      S_READ: begin
        spi_en_nxt   = 1'b1;
        spi_addr_nxt = 2'd2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oSpiEnable <= 1'b0;
      oSpiWrite  <= 1'b0;
      oSpiAddr   <= 2'd0;
      oSpiData   <= 16'h0000;
    end else begin
      oSpiEnable <= spi_en_nxt;
      oSpiWrite  <= spi_wr_nxt;
      oSpiAddr   <= spi_addr_nxt;
      oSpiData   <= spi_data_nxt;
    end
  end

  // ------------------------------------------------------------- CPU reads
  always_comb begin
    rd_data = 16'h0000;
    case (iAddr)
      2'd0: rd_data = {1'b0, tmo, ovf, (state != S_IDLE), rx_full, rx_empty,
                       tx_full, tx_empty, 5'b00000, discard, irqen, run};
      2'd1: rd_data = rx_empty ? 16'h0000 : {8'h00, rx_mem[rx_rp]};
      2'd2: rd_data = 16'(tx_cnt);
      default: rd_data = 16'(rx_cnt);
    endcase
  end

  assign oData = iEnable ? rd_data : 16'bz;
  assign oInt  = irqen && ((tx_empty && (state == S_IDLE)) || ovf || tmo);

endmodule

`default_nettype wire

// File: tb/tb_spi_stream_engine.sv
// =============================================================================
// Module   : tb_spi_stream_engine
// Purpose  : Self-checking bench for spi_stream_engine. A behavioural SPI
//            loopback peripheral echoes each transmitted byte; expected RX
//            bytes are queued when pushed and compared when the CPU pops them.
// Revision : 1.0 - initial release
// -----------------------------------------------------------------------------
// Ports    : none (top-level bench)
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_stream_engine;

  localparam int DEPTH        = 16;
  localparam int POLL_LIMIT   = 16;
  // GO arms 10 busy cycles: 10 busy polls + 1 clear poll, so LOAD, GO,
  // 11 POLL, READ -> READ strobe lands 13 cycles after the LOAD strobe.
  localparam int LOAD_TO_READ = 13;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic [15:0] wdata = 16'h0000;
  wire  [15:0] rdata;
  logic        wr = 1'b0;
  logic        en = 1'b0;
  logic        irq;
  logic [1:0]  spi_addr;
  logic [15:0] spi_dout;
  logic [15:0] spi_din;
  logic        spi_wr;
  logic        spi_en;

  always #5 clk = ~clk;

  spi_stream_engine #(.DEPTH(DEPTH), .POLL_LIMIT(POLL_LIMIT)) dut (
    .iClk      (clk),
    .iRst      (rst),
    .iAddr     (addr),
    .iData     (wdata),
    .oData     (rdata),
    .iWrite    (wr),
    .iEnable   (en),
    .oInt      (irq),
    .oSpiAddr  (spi_addr),
    .oSpiData  (spi_dout),
    .iSpiData  (spi_din),
    .oSpiWrite (spi_wr),
    .oSpiEnable(spi_en)
  );

  // ---------------------------------------------------- peripheral model
  logic [7:0] shift_q = 8'h00;
  int         busy_left = 0;
  bit         stuck = 1'b0;

  always @(posedge clk) begin
    if (spi_en && spi_wr && spi_addr == 2'd1) shift_q <= spi_dout[7:0];
    if (spi_en && spi_wr && spi_addr == 2'd0) busy_left <= 10;
    else if (busy_left != 0)                  busy_left <= busy_left - 1;
  end

  always_comb begin
    spi_din = 16'h0000;
    if (spi_addr == 2'd0)      spi_din[7]   = stuck || (busy_left != 0);
    else if (spi_addr == 2'd2) spi_din[7:0] = shift_q;
  end

  // ------------------------------------------------------------ checking
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // --------------------------------------------------------- strobe monitor
  int cyc = 0, load_cnt = 0, poll_cnt = 0, read_cnt = 0, strobe_cnt = 0, load_cyc = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (spi_en) begin
        strobe_cnt++;
        if (spi_wr && spi_addr == 2'd1) begin
          load_cnt++;
          load_cyc = cyc;
        end
        if (!spi_wr && spi_addr == 2'd0) poll_cnt++;
        if (!spi_wr && spi_addr == 2'd2) begin
          read_cnt++;
          if (!stuck) check("load_to_read", cyc - load_cyc, LOAD_TO_READ);
        end
      end
    end
  end

  // --------------------------------------------------------- CPU accesses
  logic [7:0] sb[$];

  task automatic cpu_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr = 1'b1; en = 1'b1;
    @(negedge clk);
    en = 1'b0; wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    addr = a; wr = 1'b0; en = 1'b1;
    #1 d = rdata;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic push(input logic [7:0] b, input bit to_rx);
    cpu_write(2'd1, {8'h00, b});
    if (to_rx) sb.push_back(b);
  endtask

  task automatic pop_check(input string tag);
    logic [15:0] d;
    logic [7:0]  e;
    e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
    cpu_read(2'd1, d);
    check(tag, d, {8'h00, e});
  endtask

  task automatic reg_check(input string tag, input logic [1:0] a, input logic [15:0] exp);
    logic [15:0] d;
    cpu_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic wait_reads(input int target, input string tag);
    for (int k = 0; k < 400 && read_cnt < target; k++) @(negedge clk);
    check(tag, read_cnt, target);
  endtask

  task automatic wait_poll(input int base);
    for (int k = 0; k < 50 && poll_cnt <= base; k++) @(negedge clk);
    check("poll_seen", (poll_cnt > base), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // ------------------------------------------------------------- stimulus
  initial begin
    int l0, r0, p0, s0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_en",   spi_en, 1'b0);
    check("rst_wr",   spi_wr, 1'b0);
    check("rst_addr", spi_addr, 2'd0);
    check("rst_data", spi_dout, 16'h0000);
    check("rst_irq",  irq, 1'b0);
    rst = 1'b0;
    reg_check("rst_stat", 2'd0, 16'h0500);
    reg_check("rst_txc",  2'd2, 16'h0000);
    reg_check("rst_rxc",  2'd3, 16'h0000);

    // Loopback: two bytes, RUN|IRQEN
    push(8'hA5, 1'b1);
    push(8'h3C, 1'b1);
    cpu_write(2'd0, 16'h0003);
    wait_reads(2, "lb_reads");
    @(negedge clk);
    check("lb_irq", irq, 1'b1);
    reg_check("lb_stat", 2'd0, 16'h0103);
    reg_check("lb_rxc",  2'd3, 16'h0002);
    pop_check("lb_pop0");
    pop_check("lb_pop1");
    pop_check("lb_empty_pop");

    // Overflow with RUN = 0
    cpu_write(2'd0, 16'h0000);
    for (int i = 0; i < 17; i++) push(8'h40 + 8'(i), (i < DEPTH));
    reg_check("ovf_txc",  2'd2, 16'd16);
    reg_check("ovf_stat", 2'd0, 16'h2600);
    cpu_write(2'd0, 16'h2000);
    reg_check("ovf_clr",  2'd0, 16'h0600);

    // RX stall: drain TX into RX until RX is full, then one more byte waits
    r0 = read_cnt;
    cpu_write(2'd0, 16'h0001);
    wait_reads(r0 + 16, "fill_reads");
    push(8'h77, 1'b1);
    s0 = strobe_cnt;
    repeat (20) @(negedge clk);
    check("stall_no_strobe", strobe_cnt, s0);
    reg_check("stall_stat", 2'd0, 16'h0801);
    reg_check("stall_rxc",  2'd3, 16'd16);
    l0 = load_cnt;
    pop_check("stall_pop");
    @(negedge clk);
    check("stall_resume", load_cnt, l0 + 1);
    wait_reads(r0 + 17, "resume_read");

    // DISCARD: transfers proceed with RX full, RX count unchanged
    cpu_write(2'd0, 16'h0005);
    push(8'h88, 1'b0);
    push(8'h99, 1'b0);
    wait_reads(r0 + 19, "disc_reads");
    repeat (2) @(negedge clk);
    reg_check("disc_rxc", 2'd3, 16'd16);
    reg_check("disc_txc", 2'd2, 16'd0);
    cpu_write(2'd0, 16'h0000);
    for (int i = 0; i < 16; i++) pop_check("drain_pop");
    pop_check("drain_empty");

    // Timeout: busy never clears
    stuck = 1'b1;
    p0 = poll_cnt;
    push(8'h11, 1'b0);
    cpu_write(2'd0, 16'h0003);
    repeat (60) @(negedge clk);
    check("tmo_polls", poll_cnt - p0, POLL_LIMIT);
    reg_check("tmo_stat", 2'd0, 16'h4502);
    check("tmo_irq", irq, 1'b1);
    cpu_write(2'd0, 16'h4002);
    reg_check("tmo_clr", 2'd0, 16'h0502);
    stuck = 1'b0;
    cpu_write(2'd0, 16'h0000);

    // RUN cleared during POLL: current byte completes, no further LOAD
    push(8'hC1, 1'b1);
    push(8'hC2, 1'b0);
    push(8'hC3, 1'b0);
    push(8'hC4, 1'b0);
    l0 = load_cnt; r0 = read_cnt; p0 = poll_cnt;
    cpu_write(2'd0, 16'h0001);
    wait_poll(p0);
    cpu_write(2'd0, 16'h0000);
    repeat (40) @(negedge clk);
    check("rc_loads", load_cnt, l0 + 1);
    check("rc_reads", read_cnt, r0 + 1);
    reg_check("rc_txc", 2'd2, 16'd3);
    reg_check("rc_rxc", 2'd3, 16'd1);
    pop_check("rc_pop");

    // Reset during POLL
    p0 = poll_cnt;
    cpu_write(2'd0, 16'h0003);
    wait_poll(p0);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_en",   spi_en, 1'b0);
    check("mrst_wr",   spi_wr, 1'b0);
    check("mrst_addr", spi_addr, 2'd0);
    check("mrst_data", spi_dout, 16'h0000);
    check("mrst_irq",  irq, 1'b0);
    rst = 1'b0;
    sb.delete();
    reg_check("mrst_txc",  2'd2, 16'd0);
    reg_check("mrst_rxc",  2'd3, 16'd0);
    reg_check("mrst_stat", 2'd0, 16'h0500);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
